// File: rtl/acc_cpu_pkg.sv
// acc_cpu_pkg
// Shared definitions for the accumulator CPU core: opcode values, the
// control FSM state encoding, flag bit positions and opcode class helpers.
package acc_cpu_pkg;

    localparam logic [7:0] OP_NOP    = 8'h00;
    localparam logic [7:0] OP_STORE  = 8'h01;
    localparam logic [7:0] OP_LOAD   = 8'h02;
    localparam logic [7:0] OP_ADD    = 8'h03;
    localparam logic [7:0] OP_SUB    = 8'h04;
    localparam logic [7:0] OP_JMPGEZ = 8'h05;
    localparam logic [7:0] OP_JMP    = 8'h06;
    localparam logic [7:0] OP_HALT   = 8'h07;
    localparam logic [7:0] OP_MPY    = 8'h08;
    localparam logic [7:0] OP_AND    = 8'h0A;
    localparam logic [7:0] OP_OR     = 8'h0B;
    localparam logic [7:0] OP_NOT    = 8'h0C;
    localparam logic [7:0] OP_SHR    = 8'h0D;
    localparam logic [7:0] OP_SHL    = 8'h0E;

    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_MEM    = 3'd2,
        ST_EXEC   = 3'd3,
        ST_HALT   = 3'd4
    } state_e;

    // Opcodes that need an operand cycle on the memory port.
    function automatic logic is_mem_op(input logic [7:0] op);
        return op inside {OP_STORE, OP_LOAD, OP_ADD, OP_SUB, OP_MPY, OP_AND, OP_OR};
    endfunction

    function automatic logic is_known_op(input logic [7:0] op);
        return op inside {OP_NOP, OP_STORE, OP_LOAD, OP_ADD, OP_SUB, OP_JMPGEZ, OP_JMP,
                          OP_HALT, OP_MPY, OP_AND, OP_OR, OP_NOT, OP_SHR, OP_SHL};
    endfunction

    // Opcodes whose ALU result lands in ACC and refreshes the flags.
    function automatic logic writes_acc(input logic [7:0] op);
        return op inside {OP_LOAD, OP_ADD, OP_SUB, OP_MPY, OP_AND, OP_OR,
                          OP_NOT, OP_SHR, OP_SHL};
    endfunction

endpackage

// File: rtl/acc_cpu_alu.sv
// acc_cpu_alu
// Combinational ALU for the accumulator CPU.
// Ports:
//   op_i      opcode of the instruction in EXEC
//   acc_i     current accumulator
//   br_i      operand fetched from memory
//   result_o  new ACC value (ACC unchanged for opcodes without a result)
//   mr_o      high word of the signed product (meaningful for MPY only)
//   flags_o   {Z,N,C,V} for the result
module acc_cpu_alu
    import acc_cpu_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic [7:0]        op_i,
    input  logic [DATA_W-1:0] acc_i,
    input  logic [DATA_W-1:0] br_i,
    output logic [DATA_W-1:0] result_o,
    output logic [DATA_W-1:0] mr_o,
    output logic [3:0]        flags_o
);

    localparam int MSB = DATA_W - 1;

    logic [DATA_W:0]     sum;
    logic [DATA_W:0]     diff;
    logic [2*DATA_W-1:0] a_ext;
    logic [2*DATA_W-1:0] b_ext;
    logic [2*DATA_W-1:0] prod;
    logic                carry;
    logic                ovf;
    logic                neg;

    assign sum   = {1'b0, acc_i} + {1'b0, br_i};
    // The extra top bit of the difference is the borrow.
    assign diff  = {1'b0, acc_i} - {1'b0, br_i};
    // The low 2*DATA_W bits of an unsigned product of sign-extended operands
    // equal the signed product.
    assign a_ext = {{DATA_W{acc_i[MSB]}}, acc_i};
    assign b_ext = {{DATA_W{br_i[MSB]}}, br_i};
    assign prod  = a_ext * b_ext;
    assign mr_o  = prod[2*DATA_W-1:DATA_W];

    always_comb begin
        result_o = acc_i;
        carry    = 1'b0;
        ovf      = 1'b0;
        case (op_i)
            OP_LOAD: result_o = br_i;
            OP_ADD: begin
                result_o = sum[MSB:0];
                carry    = sum[DATA_W];
                ovf      = (acc_i[MSB] == br_i[MSB]) && (sum[MSB] != acc_i[MSB]);
            end
            OP_SUB: begin
                result_o = diff[MSB:0];
                carry    = diff[DATA_W];
                ovf      = (acc_i[MSB] != br_i[MSB]) && (diff[MSB] != acc_i[MSB]);
            end
            OP_MPY: begin
                result_o = prod[MSB:0];
                ovf      = (prod[2*DATA_W-1:DATA_W] != {DATA_W{prod[MSB]}});
            end
            OP_AND: result_o = acc_i & br_i;
            OP_OR:  result_o = acc_i | br_i;
            OP_NOT: result_o = ~acc_i;
            OP_SHR: begin
                result_o = {acc_i[MSB], acc_i[MSB:1]};
                carry    = acc_i[0];
            end
            OP_SHL: begin
                result_o = {acc_i[MSB-1:0], 1'b0};
                carry    = acc_i[MSB];
            end
            default: ;
        endcase
        // N follows the sign of the full product for MPY, Z only the ACC half.
        neg     = (op_i == OP_MPY) ? prod[2*DATA_W-1] : result_o[MSB];
        flags_o = {(result_o == '0), neg, carry, ovf};
    end

endmodule

// File: rtl/acc_cpu_core.sv
// acc_cpu_core
// Multi-cycle accumulator CPU with a req/ack memory port.
// Ports:
//   clk, rst_n          system clock, asynchronous active-low reset
//   continue_flag       resume from HALT on a rising edge
//   mem_req/we/addr     memory request (held until mem_ack), write enable, address (MAR)
//   mem_wdata/rdata     write data (MBR), read data valid with mem_ack
//   mem_ack             one-cycle completion strobe
//   acc_data, mr_data   accumulator and multiply high word
//   pc_data             program counter
//   alu_flags           {Z,N,C,V} of the last flag-updating instruction
//   halted, illegal_op  in HALT; one-cycle pulse on an unknown opcode
//
// state  | meaning
// FETCH  | read instruction at PC; on ack latch MBR/IR, PC+1
// DECODE | MAR <- operand address; STORE loads MBR <- ACC
// MEM    | operand read (BR) or STORE write
// EXEC   | ALU writeback / jump / enter HALT
// HALT   | wait for continue_flag rising edge
module acc_cpu_core
    import acc_cpu_pkg::*;
#(
    parameter int                DATA_W   = 16,
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              continue_flag,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [DATA_W-1:0] acc_data,
    output logic [DATA_W-1:0] mr_data,
    output logic [ADDR_W-1:0] pc_data,
    output logic [3:0]        alu_flags,
    output logic              halted,
    output logic              illegal_op
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] mar_q, mar_d;
    logic [DATA_W-1:0] mbr_q, mbr_d;
    logic [7:0]        ir_q, ir_d;
    logic [DATA_W-1:0] br_q, br_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0] mr_q, mr_d;
    logic [3:0]        flags_q, flags_d;
    logic              req_q, req_d;
    logic              illegal_q, illegal_d;
    logic              cont_prev_q;

    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] alu_mr;
    logic [3:0]        alu_flags_w;
    logic              jump_taken;
    logic [ADDR_W-1:0] exec_pc;

    acc_cpu_alu #(.DATA_W(DATA_W)) u_alu (
        .op_i     (ir_q),
        .acc_i    (acc_q),
        .br_i     (br_q),
        .result_o (alu_result),
        .mr_o     (alu_mr),
        .flags_o  (alu_flags_w)
    );

    // MAR still holds the operand address X during EXEC.
    assign jump_taken = (ir_q == OP_JMP) || ((ir_q == OP_JMPGEZ) && !acc_q[DATA_W-1]);
    assign exec_pc    = jump_taken ? mar_q : pc_q;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        mar_d     = mar_q;
        mbr_d     = mbr_q;
        ir_d      = ir_q;
        br_d      = br_q;
        acc_d     = acc_q;
        mr_d      = mr_q;
        flags_d   = flags_q;
        req_d     = req_q;
        illegal_d = 1'b0;
        case (state_q)
            ST_FETCH: begin
                if (!req_q) begin
                    // Only reachable straight after reset: start the first fetch.
                    req_d = 1'b1;
                    mar_d = pc_q;
                end else if (mem_ack) begin
                    mbr_d   = mem_rdata;
                    ir_d    = mem_rdata[DATA_W-1 -: 8];
                    pc_d    = pc_q + ADDR_W'(1);
                    req_d   = 1'b0;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                mar_d     = mbr_q[ADDR_W-1:0];
                illegal_d = !is_known_op(ir_q);
                if (is_mem_op(ir_q)) begin
                    state_d = ST_MEM;
                    req_d   = 1'b1;
                    if (ir_q == OP_STORE) begin
                        mbr_d = acc_q;
                    end
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_MEM: begin
                if (mem_ack) begin
                    if (ir_q != OP_STORE) begin
                        br_d = mem_rdata;
                    end
                    req_d   = 1'b0;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (writes_acc(ir_q)) begin
                    acc_d   = alu_result;
                    flags_d = alu_flags_w;
                    if (ir_q == OP_MPY) begin
                        mr_d = alu_mr;
                    end
                end
                pc_d = exec_pc;
                if (ir_q == OP_HALT) begin
                    state_d = ST_HALT;
                end else begin
                    state_d = ST_FETCH;
                    req_d   = 1'b1;
                    mar_d   = exec_pc;
                end
            end
            ST_HALT: begin
                if (continue_flag && !cont_prev_q) begin
                    state_d = ST_FETCH;
                    req_d   = 1'b1;
                    mar_d   = pc_q;
                end
            end
            default: begin
                state_d = ST_FETCH;
                req_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_FETCH;
            pc_q        <= RESET_PC;
            mar_q       <= '0;
            mbr_q       <= '0;
            ir_q        <= '0;
            br_q        <= '0;
            acc_q       <= '0;
            mr_q        <= '0;
            flags_q     <= '0;
            req_q       <= 1'b0;
            illegal_q   <= 1'b0;
            cont_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            mar_q       <= mar_d;
            mbr_q       <= mbr_d;
            ir_q        <= ir_d;
            br_q        <= br_d;
            acc_q       <= acc_d;
            mr_q        <= mr_d;
            flags_q     <= flags_d;
            req_q       <= req_d;
            illegal_q   <= illegal_d;
            cont_prev_q <= continue_flag;
        end
    end

    assign mem_req    = req_q;
    assign mem_we     = (state_q == ST_MEM) && (ir_q == OP_STORE);
    assign mem_addr   = mar_q;
    assign mem_wdata  = mbr_q;
    assign acc_data   = acc_q;
    assign mr_data    = mr_q;
    assign pc_data    = pc_q;
    assign alu_flags  = flags_q;
    assign halted     = (state_q == ST_HALT);
    assign illegal_op = illegal_q;

endmodule

// File: tb/tb_acc_cpu_core.sv
module tb_acc_cpu_core;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        continue_flag = 1'b0;
    logic        mem_req;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata = 16'h0;
    logic        mem_ack = 1'b0;
    logic [15:0] acc_data;
    logic [15:0] mr_data;
    logic [7:0]  pc_data;
    logic [3:0]  alu_flags;
    logic        halted;
    logic        illegal_op;

    int n_checks = 0;
    int n_errors = 0;

    acc_cpu_core #(.DATA_W(16), .ADDR_W(8), .RESET_PC(8'h00)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .continue_flag (continue_flag),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata),
        .mem_ack       (mem_ack),
        .acc_data      (acc_data),
        .mr_data       (mr_data),
        .pc_data       (pc_data),
        .alu_flags     (alu_flags),
        .halted        (halted),
        .illegal_op    (illegal_op)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ---------------- memory with random wait states ----------------
    logic [15:0] mem [256];
    int          max_wait = 0;
    bit          spurious_en = 0;
    int          wait_left = 0;
    bit          in_txn = 0;
    bit          waited = 0;
    logic [7:0]  cap_addr;
    logic        cap_we;
    logic [15:0] cap_wdata;
    int          addr_max = 0;
    int          ill_cnt = 0;

    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_ack = 1'b0;
            in_txn  = 0;
            waited  = 0;
        end else begin
            mem_ack   = 1'b0;
            mem_rdata = 16'($urandom);
            if (mem_req) begin
                if (!in_txn) begin
                    in_txn    = 1;
                    waited    = 0;
                    cap_addr  = mem_addr;
                    cap_we    = mem_we;
                    cap_wdata = mem_wdata;
                    wait_left = $urandom_range(max_wait, 0);
                end
                if (wait_left == 0) begin
                    mem_ack   = 1'b1;
                    mem_rdata = mem[mem_addr];
                    if (mem_we) mem[mem_addr] = mem_wdata;
                    if (waited)
                        chk("hs_stable", {7'h0, mem_addr, mem_we, mem_wdata},
                            {7'h0, cap_addr, cap_we, cap_wdata});
                    if (int'(mem_addr) > addr_max) addr_max = int'(mem_addr);
                    in_txn = 0;
                end else begin
                    wait_left--;
                    waited = 1;
                end
            end else if (spurious_en) begin
                mem_ack = 1'($urandom_range(1, 0));
            end
        end
    end

    always @(negedge clk) if (illegal_op === 1'b1) ill_cnt++;

    // ---------------- ISA-level reference model ----------------
    logic [15:0] img [256];
    logic [15:0] saved [256];
    logic [15:0] mm [256];
    logic [15:0] m_acc, m_mr;
    logic [3:0]  m_fl;
    logic [7:0]  m_pc;
    int          m_ill;

    function automatic logic [15:0] ins(input logic [7:0] op, input logic [7:0] x);
        return {op, x};
    endfunction

    task automatic model_run();
        logic [15:0] w, m, res;
        logic [7:0]  op, x;
        int          sa, sm, s;
        longint      p;
        logic        c, v, n;
        bit          upd, done;
        int          steps;
        done = 0;
        steps = 0;
        while (!done && steps < 2000) begin
            w = mm[m_pc];
            op = w[15:8];
            x = w[7:0];
            m_pc = m_pc + 8'd1;
            m = mm[x];
            steps++;
            sa = int'($signed(m_acc));
            sm = int'($signed(m));
            res = m_acc; c = 0; v = 0; upd = 1; p = 0;
            case (op)
                8'h00: upd = 0;
                8'h01: begin mm[x] = m_acc; upd = 0; end
                8'h02: res = m;
                8'h03: begin
                    s = int'(m_acc) + int'(m); res = s[15:0]; c = (s > 65535);
                    v = (sa + sm > 32767) || (sa + sm < -32768);
                end
                8'h04: begin
                    s = int'(m_acc) - int'(m); res = s[15:0]; c = (m_acc < m);
                    v = (sa - sm > 32767) || (sa - sm < -32768);
                end
                8'h05: begin upd = 0; if (sa >= 0) m_pc = x; end
                8'h06: begin upd = 0; m_pc = x; end
                8'h07: begin upd = 0; done = 1; end
                8'h08: begin
                    p = longint'(sa) * longint'(sm);
                    res = p[15:0]; m_mr = p[31:16];
                    v = (p > 32767) || (p < -32768);
                end
                8'h0A: res = m_acc & m;
                8'h0B: res = m_acc | m;
                8'h0C: res = ~m_acc;
                8'h0D: begin c = m_acc[0]; s = sa >>> 1; res = s[15:0]; end
                8'h0E: begin c = m_acc[15]; s = int'(m_acc) * 2; res = s[15:0]; end
                default: begin upd = 0; m_ill++; end
            endcase
            if (upd) begin
                m_acc = res;
                n = (op == 8'h08) ? (p < 0) : res[15];
                m_fl = {(res == 16'h0), n, c, v};
            end
        end
    endtask

    task automatic load_img();
        for (int i = 0; i < 256; i++) begin
            mem[i] = img[i];
            mm[i]  = img[i];
        end
        m_acc = 16'h0; m_mr = 16'h0; m_fl = 4'h0; m_pc = 8'h00; m_ill = 0;
    endtask

    task automatic clear_img();
        for (int i = 0; i < 256; i++) img[i] = 16'h0;
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        ill_cnt = 0;
        addr_max = 0;
        rst_n = 1'b1;
    endtask

    task automatic wait_halt(input int start, output int cyc);
        cyc = start;
        while (halted !== 1'b1 && cyc < 3000) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("halt_reached", 32'(halted), 32'd1);
    endtask

    task automatic resume();
        int k;
        continue_flag = 1'b0;
        @(negedge clk); @(negedge clk);
        continue_flag = 1'b1;
        k = 0;
        while (halted === 1'b1 && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        chk("resume_left_halt", 32'(halted), 32'd0);
        continue_flag = 1'b0;
    endtask

    task automatic compare_model(input string tag);
        int nmis;
        nmis = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== mm[i]) nmis++;
        chk({tag, "_acc"}, 32'(acc_data), 32'(m_acc));
        chk({tag, "_mr"}, 32'(mr_data), 32'(m_mr));
        chk({tag, "_flags"}, 32'(alu_flags), 32'(m_fl));
        chk({tag, "_pc"}, 32'(pc_data), 32'(m_pc));
        chk({tag, "_mem"}, 32'(nmis), 32'd0);
        chk({tag, "_illegal"}, 32'(ill_cnt), 32'(m_ill));
    endtask

    task automatic gen_random_prog();
        logic [7:0] ops [12];
        logic [7:0] op;
        ops = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h08, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h00, 8'h05};
        clear_img();
        for (int i = 0; i < 20; i++) begin
            op = ops[$urandom_range(11, 0)];
            if (op == 8'h05) begin
                if (i < 19) img[i] = ins(op, 8'(i + 2));
                else        img[i] = ins(8'h09, 8'h00);
            end else begin
                img[i] = ins(op, 8'($urandom_range(95, 64)));
            end
        end
        img[20] = ins(8'h07, 8'h00);
        for (int i = 64; i < 96; i++) img[i] = 16'($urandom);
    endtask

    initial begin
        int cyc;
        int k;
        int nmis;

        // ---- reset state ----
        #1 rst_n = 1'b0;
        #1;
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_illegal", 32'(illegal_op), 32'd0);
        chk("rst_pc", 32'(pc_data), 32'd0);
        chk("rst_acc", 32'(acc_data), 32'd0);
        chk("rst_mr", 32'(mr_data), 32'd0);
        chk("rst_flags", 32'(alu_flags), 32'd0);

        // ---- LOAD/ADD/STORE/HALT, zero wait ----
        clear_img();
        img[0] = ins(8'h02, 8'd10); img[1] = ins(8'h03, 8'd11);
        img[2] = ins(8'h01, 8'd12); img[3] = ins(8'h07, 8'd0);
        img[10] = 16'd5; img[11] = 16'd7;
        load_img();
        reset_dut();
        @(posedge clk); #1;
        chk("first_req", 32'(mem_req), 32'd1);
        chk("first_addr", 32'(mem_addr), 32'd0);
        wait_halt(1, cyc);
        chk("latency_cycles", 32'(cyc), 32'd16);
        chk("a_mem12", 32'(mem[12]), 32'd12);
        chk("a_flags", 32'(alu_flags), 32'h0);
        chk("a_pc", 32'(pc_data), 32'd4);
        model_run();
        compare_model("a");

        // ---- SUB 3-5 ----
        clear_img();
        img[0] = ins(8'h02, 8'd10); img[1] = ins(8'h04, 8'd11); img[2] = ins(8'h07, 8'd0);
        img[10] = 16'd3; img[11] = 16'd5;
        load_img(); reset_dut(); wait_halt(0, cyc);
        chk("sub_acc", 32'(acc_data), 32'h0000FFFE);
        chk("sub_flags", 32'(alu_flags), 32'b0110);

        // ---- ADD overflow ----
        img[1] = ins(8'h03, 8'd11);
        img[10] = 16'h7FFF; img[11] = 16'h0001;
        load_img(); reset_dut(); wait_halt(0, cyc);
        chk("addv_acc", 32'(acc_data), 32'h00008000);
        chk("addv_flags", 32'(alu_flags), 32'b0101);

        // ---- MPY pair with a resume between ----
        clear_img();
        img[0] = ins(8'h02, 8'd10); img[1] = ins(8'h08, 8'd11); img[2] = ins(8'h07, 8'd0);
        img[3] = ins(8'h02, 8'd12); img[4] = ins(8'h08, 8'd13); img[5] = ins(8'h07, 8'd0);
        img[10] = 16'h0100; img[11] = 16'h0100; img[12] = 16'hFFFD; img[13] = 16'h0004;
        load_img(); reset_dut(); wait_halt(0, cyc);
        chk("mpy1_acc", 32'(acc_data), 32'h0);
        chk("mpy1_mr", 32'(mr_data), 32'h1);
        chk("mpy1_flags", 32'(alu_flags), 32'b1001);
        model_run();
        compare_model("mpy1");
        resume();
        wait_halt(0, cyc);
        chk("mpy2_acc", 32'(acc_data), 32'h0000FFF4);
        chk("mpy2_mr", 32'(mr_data), 32'h0000FFFF);
        chk("mpy2_flags", 32'(alu_flags), 32'b0100);
        model_run();
        compare_model("mpy2");

        // ---- random programs: zero wait, then 0-3 waits with spurious acks ----
        for (int r = 0; r < 3; r++) begin
            gen_random_prog();
            max_wait = 0; spurious_en = 0;
            load_img(); reset_dut(); wait_halt(0, cyc);
            model_run();
            compare_model("rnd_zw");
            for (int i = 0; i < 256; i++) saved[i] = mem[i];
            max_wait = 3; spurious_en = 1;
            load_img(); reset_dut(); wait_halt(0, cyc);
            model_run();
            compare_model("rnd_ws");
            nmis = 0;
            for (int i = 0; i < 256; i++) if (mem[i] !== saved[i]) nmis++;
            chk("rnd_same_image", 32'(nmis), 32'd0);
        end
        max_wait = 0; spurious_en = 0;

        // ---- HALT with continue already high, then a real edge ----
        clear_img();
        img[0] = ins(8'h07, 8'd0); img[1] = ins(8'h02, 8'd20); img[2] = ins(8'h07, 8'd0);
        img[20] = 16'h1234;
        load_img();
        continue_flag = 1'b1;
        reset_dut(); wait_halt(0, cyc);
        repeat (10) @(posedge clk);
        #1;
        chk("held_high_stays", 32'(halted), 32'd1);
        chk("held_high_pc", 32'(pc_data), 32'd1);
        resume();
        wait_halt(0, cyc);
        model_run(); model_run();
        compare_model("resume");

        // ---- illegal opcode ----
        clear_img();
        img[0] = ins(8'h02, 8'd20); img[1] = 16'hFF00; img[2] = ins(8'h07, 8'd0);
        img[20] = 16'h8000;
        load_img(); reset_dut(); wait_halt(0, cyc);
        chk("illegal_pulses", 32'(ill_cnt), 32'd1);
        chk("illegal_acc", 32'(acc_data), 32'h8000);
        chk("illegal_flags", 32'(alu_flags), 32'b0100);
        chk("illegal_pc", 32'(pc_data), 32'd3);

        // ---- PC wrap 255 -> 0, JMPGEZ taken then not taken ----
        clear_img();
        img[0] = ins(8'h05, 8'hFF); img[1] = ins(8'h07, 8'd0); img[255] = ins(8'h0C, 8'd0);
        load_img(); reset_dut(); wait_halt(0, cyc);
        chk("wrap_acc", 32'(acc_data), 32'h0000FFFF);
        chk("wrap_pc", 32'(pc_data), 32'd2);
        model_run();
        compare_model("wrap");

        // ---- jump to self ----
        clear_img();
        img[0] = ins(8'h06, 8'd0);
        load_img(); reset_dut();
        repeat (60) @(posedge clk);
        #1;
        chk("self_not_halted", 32'(halted), 32'd0);
        chk("self_pc", 32'(pc_data >> 1), 32'd0);
        chk("self_addr_max", 32'(addr_max), 32'd0);

        // ---- reset in the middle of a fetch ----
        gen_random_prog();
        max_wait = 2;
        load_img(); reset_dut();
        k = 0;
        while (!(mem_req === 1'b1 && mem_addr == pc_data && pc_data > 8'd3) && k < 500) begin
            @(posedge clk); #1;
            k++;
        end
        chk("midfetch_found", 32'(k < 500), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("midfetch_req", 32'(mem_req), 32'd0);
        chk("midfetch_pc", 32'(pc_data), 32'd0);
        chk("midfetch_acc", 32'(acc_data), 32'd0);
        chk("midfetch_halted", 32'(halted), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        max_wait = 0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/acc_cpu_core.md
# acc_cpu_core

Parametrised accumulator CPU core, the successor to the fixed 16-bit/8-bit-address simple CPU. Register set: PC, MAR, MBR, IR, BR, ACC and MR, driven by a multi-cycle control FSM.
- Data width, address width and reset vector are parameters.
- The single-cycle RAM port is replaced by a req/ack memory handshake, so wait-state memories work.
- MR holds the multiply high word; SHL, SHR and NOT are added.
- HALT resumes on a continue pulse; illegal opcodes are reported.
- Sits between the board top (seven-segment display, switches) and a block RAM or bus bridge.

## Interface
Parameters:
- DATA_W, 16: word width. Minimum 8+ADDR_W.
- ADDR_W, 8: memory address width.
- RESET_PC, 0: PC value after reset.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous and active-low.
- continue_flag  in  1  resume from HALT. Level input; a rising edge is detected internally.
- mem_req  out  1  memory request, held until acknowledged.
- mem_we  out  1  1 = write, 0 = read. Valid while mem_req is high.
- mem_addr  out  ADDR_W  word address (MAR).
- mem_wdata  out  DATA_W  write data (MBR).
- mem_rdata  in  DATA_W  read data. Valid in the cycle mem_ack is high.
- mem_ack  in  1  one-cycle completion strobe.
- acc_data  out  DATA_W  ACC contents.
- mr_data  out  DATA_W  MR contents (multiply high word).
- pc_data  out  ADDR_W  PC contents.
- alu_flags  out  4  {Z,N,C,V} from the last ALU operation.
- halted  out  1  high while in state HALT.
- illegal_op  out  1  one-cycle pulse on an unknown opcode.

## Operation
Instruction format:
- opcode = word[DATA_W-1 -: 8].
- operand address X = word[ADDR_W-1:0].
- Bits in between are ignored.

Opcodes (acting on M = mem[X]):
- 00 NOP
- 01 STORE: mem[X] ← ACC
- 02 LOAD: ACC ← M
- 03 ADD: ACC ← ACC+M
- 04 SUB: ACC ← ACC−M
- 05 JMPGEZ: if ACC ≥ 0 (signed), PC ← X
- 06 JMP: PC ← X
- 07 HALT
- 08 MPY: {MR,ACC} ← signed ACC×M, full 2·DATA_W product
- 0A AND
- 0B OR
- 0C NOT: ACC ← ~ACC
- 0D SHR: arithmetic shift right by 1
- 0E SHL: logical shift left by 1
- Any other opcode: illegal_op pulse, then executes as NOP.

FSM states: FETCH → DECODE → [MEM] → EXEC → FETCH. HALT exits only via the resume rule.
- FETCH: mem_req=1, we=0, addr=PC. On ack: MBR←rdata, IR←opcode, PC←PC+1 (wraps mod 2^ADDR_W).
- DECODE: MAR←X.
  - Memory opcodes (STORE, LOAD, ADD, SUB, MPY, AND, OR) go to MEM.
  - All other opcodes go to EXEC.
  - STORE also loads MBR←ACC here.
- MEM: mem_req=1, addr=MAR, we=1 only for STORE. For reads, on ack: BR←rdata.
- EXEC:
  - ALU result is written to ACC; flags are updated.
  - Jumps load PC.
  - HALT enters HALT state.
  - STORE, NOP, JMP and JMPGEZ leave flags unchanged.

Flag rules:
- Z = result==0 (ACC part only for MPY).
- N = result MSB.
- C = carry-out for ADD, borrow for SUB, shifted-out bit for shifts. C = 0 for logic ops and MPY.
- V = signed overflow for ADD/SUB; for MPY, 1 when the high word is not the sign extension of ACC. V = 0 otherwise.
- MR changes only on MPY.

HALT resume rule: leave HALT on a continue_flag rising edge (previous sample 0, current sample 1). A level that is already high on entry does not resume.

## Timing
- Reset (async assert, sync deassert behaviour):
  - PC=RESET_PC.
  - All other registers = 0; flags = 0.
  - State FETCH; mem_req=0, halted=0, illegal_op=0.
- First request: mem_req rises in the first clock after rst_n is released.
- Handshake:
  - mem_req is registered.
  - addr, we and wdata stay stable from req rise to the ack cycle.
  - mem_ack is honoured in any cycle with req high, including the first.
  - mem_req falls in the cycle after ack.
  - mem_ack while req is low is ignored.
- Latency with zero-wait memory (ack in the first req cycle):
  - Non-memory instruction: 3 cycles.
  - Memory instruction: 4 cycles.
  - Each wait cycle adds 1 cycle.
- Reset mid-transaction: mem_req drops asynchronously and the transaction is abandoned.
- PC wrap: PC=2^ADDR_W−1 fetch → PC=0.
- Jump to self: legal, loops forever.
- continue_flag outside HALT: ignored.

## Structure
- Shared package `acc_cpu_pkg`: opcode localparams, FSM state enum, flag bit indices (Z=3, N=2, C=1, V=0).
- One sub-module, `acc_cpu_alu`: combinational, parametrised by DATA_W. Inputs opcode, ACC, BR; outputs result, MR result and flags.
- Registers and FSM live in the core.

## Test plan
- Reset, zero-wait memory: program LOAD 10; ADD 11; STORE 12; HALT with mem[10]=5, mem[11]=7 → mem[12]=12, halted=1, flags Z=0, N=0, PC=4.
- SUB 3−5 at DATA_W=16 → ACC=0xFFFE, N=1, C=1. ADD 0x7FFF+1 → V=1, N=1.
- MPY 0x0100 × 0x0100 → ACC=0, MR=1, Z=1, V=1. Then (−3)×4 → ACC=0xFFF4, MR=0xFFFF, V=0.
- Random 0–3 ack wait states on every access → same final memory image as the zero-wait run. Addr, we and wdata stable while req is high.
- HALT with continue_flag already held high → stays halted. Drop to 0 then raise → resumes at the next PC. Assert rst_n low mid-fetch → mem_req=0 immediately, PC=RESET_PC.
- Illegal opcode 0xFF → one illegal_op pulse, ACC and flags unchanged. PC wrap test at ADDR_W=4: JMP 15; NOP at 15 → next fetch address 0.
